// File: rtl/crc_frame_scheduler.sv
// rtl/crc_frame_scheduler.sv - two-requester round-robin frame scheduler with shared CRC-16 engine
module crc_frame_scheduler #(
    parameter int                   CRC_WIDTH = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 16'h8005,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT  = 16'hFFFF,
    parameter int                   MAX_LEN   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_src,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO} state_t;

    state_t               state;
    state_t               next_state;
    logic [CRC_WIDTH-1:0] crc;
    logic [7:0]           count;
    logic                 ptr;
    logic                 grant_src;
    logic                 out_free;
    logic                 sel_valid;
    logic [7:0]           sel_data;
    logic                 sel_last;
    logic                 accept;
    logic                 count_hit;

    // LSB-first bit order into an MSB-shifting register
    function automatic logic [CRC_WIDTH-1:0] crc_byte(input logic [CRC_WIDTH-1:0] c,
                                                      input logic [7:0] d);
        logic [CRC_WIDTH-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[CRC_WIDTH-1] ^ d[i])
                r = (r << 1) ^ CRC_POLY;
            else
                r = r << 1;
        end
        return r;
    endfunction

    assign grant_src  = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign out_free   = !out_valid || out_ready;
    assign sel_valid  = out_src ? req1_valid : req0_valid;
    assign sel_data   = out_src ? req1_data  : req0_data;
    assign sel_last   = out_src ? req1_last  : req0_last;
    assign req0_ready = (state == PAYLOAD) && !out_src && out_free;
    assign req1_ready = (state == PAYLOAD) &&  out_src && out_free;
    assign accept     = (state == PAYLOAD) && sel_valid && out_free;
    assign count_hit  = (int'(count) + 1) == MAX_LEN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req0_valid || req1_valid) next_state = PAYLOAD;
            PAYLOAD: if (accept && (sel_last || count_hit)) next_state = CRC_HI;
            CRC_HI:  if (out_free) next_state = CRC_LO;
            CRC_LO:  if (out_ready && out_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // CRC_LO uses out_last to tell "low byte not yet loaded" from "low byte on the bus"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= 8'h00;
            crc       <= CRC_INIT;
            count     <= 8'h00;
            ptr       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        out_src <= grant_src;
                        crc     <= CRC_INIT;
                        count   <= 8'h00;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        out_data  <= sel_data;
                        out_valid <= 1'b1;
                        count     <= count + 8'd1;
                        crc       <= crc_byte(crc, sel_data);
                        frame_err <= !sel_last && count_hit;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                CRC_HI: begin
                    if (out_free) begin
                        out_data  <= crc[CRC_WIDTH-1 -: 8];
                        out_valid <= 1'b1;
                    end
                end
                CRC_LO: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            frame_cnt <= frame_cnt + 8'd1;
                            ptr       <= !out_src;
                        end else begin
                            out_data <= crc[7:0];
                            out_last <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// tb/tb_crc_frame_scheduler.sv - self-checking bench for crc_frame_scheduler
module tb_crc_frame_scheduler;

    logic       clk;
    logic       rst;
    logic       r_valid [4];
    logic [7:0] r_data  [4];
    logic       r_last  [4];
    logic       r_ready [4];
    logic       o_valid [2];
    logic [7:0] o_data  [2];
    logic       o_last  [2];
    logic       o_src   [2];
    logic       o_ready [2];
    logic       ferr    [2];
    logic [7:0] fcnt    [2];

    bit [8:0] txq [4][$];
    bit [9:0] rxq [2][$];
    bit [9:0] expq [2][$];
    int       rdy_pat [2][$];
    bit       rdy_rand [2];
    bit       held [2];
    bit [9:0] hsave [2];
    int       nerr [2];
    int       exp_err [2];
    int       exp_cnt [2];
    bit       ptr [2];
    bit [8:0] mb [2][$];
    int       ml [2][$];
    int       checks;
    int       failures;
    int       cyc;

    crc_frame_scheduler dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(r_valid[0]), .req0_data(r_data[0]), .req0_last(r_last[0]), .req0_ready(r_ready[0]),
        .req1_valid(r_valid[1]), .req1_data(r_data[1]), .req1_last(r_last[1]), .req1_ready(r_ready[1]),
        .out_valid(o_valid[0]), .out_data(o_data[0]), .out_last(o_last[0]), .out_src(o_src[0]),
        .out_ready(o_ready[0]), .frame_err(ferr[0]), .frame_cnt(fcnt[0])
    );

    crc_frame_scheduler #(.MAX_LEN(4)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(r_valid[2]), .req0_data(r_data[2]), .req0_last(r_last[2]), .req0_ready(r_ready[2]),
        .req1_valid(r_valid[3]), .req1_data(r_data[3]), .req1_last(r_last[3]), .req1_ready(r_ready[3]),
        .out_valid(o_valid[1]), .out_data(o_data[1]), .out_last(o_last[1]), .out_src(o_src[1]),
        .out_ready(o_ready[1]), .frame_err(ferr[1]), .frame_cnt(fcnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC of a whole frame, straight from the bit-serial rule
    function automatic logic [15:0] crc_frame(input bit [7:0] bytes [$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (bytes[n])
            for (int b = 0; b < 8; b++) begin
                fb = c[15] ^ bytes[n][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        return c;
    endfunction

    task automatic add_frame(input int k, input int len, input int fixed = -1);
        bit [7:0] d;
        for (int j = 0; j < len; j++) begin
            d = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
            txq[k].push_back({(j == len - 1), d});
        end
    endtask

    // Expected output: split each requester stream into frames, then serve them round-robin
    task automatic model(input int i, input int maxlen);
        int       fi [2];
        int       pos [2];
        int       n;
        int       s;
        bit [7:0] fb [$];
        logic [15:0] c;
        for (int r = 0; r < 2; r++) begin
            mb[r] = txq[2 * i + r];
            ml[r].delete();
            n = 0;
            foreach (mb[r][j]) begin
                n++;
                if (mb[r][j][8]) begin
                    ml[r].push_back(n);
                    n = 0;
                end else if (n == maxlen) begin
                    ml[r].push_back(n);
                    n = 0;
                    exp_err[i]++;
                end
            end
            fi[r]  = 0;
            pos[r] = 0;
        end
        while (fi[0] < ml[0].size() || fi[1] < ml[1].size()) begin
            if (fi[0] < ml[0].size() && fi[1] < ml[1].size())
                s = int'(ptr[i]);
            else
                s = (fi[0] < ml[0].size()) ? 0 : 1;
            fb.delete();
            for (int j = 0; j < ml[s][fi[s]]; j++) begin
                fb.push_back(mb[s][pos[s] + j][7:0]);
                expq[i].push_back({s[0], 1'b0, mb[s][pos[s] + j][7:0]});
            end
            c = crc_frame(fb);
            expq[i].push_back({s[0], 1'b0, c[15:8]});
            expq[i].push_back({s[0], 1'b1, c[7:0]});
            pos[s] += ml[s][fi[s]];
            fi[s]++;
            ptr[i] = (s == 0);
            exp_cnt[i]++;
        end
    endtask

    task automatic step();
        bit acc [4];
        @(negedge clk);
        for (int k = 0; k < 4; k++) acc[k] = r_valid[k] && r_ready[k];
        for (int i = 0; i < 2; i++) begin
            if (held[i])
                chk($sformatf("stall_hold%0d", i), {5'b0, o_valid[i], o_src[i], o_last[i], o_data[i]},
                    {5'b0, 1'b1, hsave[i]});
            held[i]  = o_valid[i] && !o_ready[i];
            hsave[i] = {o_src[i], o_last[i], o_data[i]};
            if (o_valid[i] && o_ready[i]) rxq[i].push_back({o_src[i], o_last[i], o_data[i]});
            if (ferr[i]) nerr[i]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (acc[k]) void'(txq[k].pop_front());
        for (int k = 0; k < 4; k++) begin
            r_valid[k] = txq[k].size() > 0;
            r_data[k]  = (txq[k].size() > 0) ? txq[k][0][7:0] : 8'h00;
            r_last[k]  = (txq[k].size() > 0) ? txq[k][0][8] : 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (rdy_pat[i].size() > 0)
                o_ready[i] = rdy_pat[i].pop_front() != 0;
            else
                o_ready[i] = rdy_rand[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic run_check(input int i, input int maxlen);
        rxq[i].delete();
        expq[i].delete();
        nerr[i]    = 0;
        exp_err[i] = 0;
        model(i, maxlen);
        cyc = 0;
        while (!(txq[2 * i].size() == 0 && txq[2 * i + 1].size() == 0 &&
                 rxq[i].size() >= expq[i].size()) && cyc < 20000) begin
            step();
            cyc++;
        end
        for (int n = 0; n < 3; n++) step();
        chk($sformatf("timeout%0d", i), 16'(cyc < 20000), 16'd1);
        chk($sformatf("rx_count%0d", i), 16'(rxq[i].size()), 16'(expq[i].size()));
        foreach (expq[i][n])
            if (n < rxq[i].size())
                chk($sformatf("i%0d_byte%0d", i, n), 16'(rxq[i][n]), 16'(expq[i][n]));
        chk($sformatf("frame_cnt%0d", i), 16'(fcnt[i]), 16'(exp_cnt[i] % 256));
        chk($sformatf("frame_err_cnt%0d", i), 16'(nerr[i]), 16'(exp_err[i]));
    endtask

    task automatic clear_tb();
        for (int k = 0; k < 4; k++) begin
            txq[k].delete();
            r_valid[k] = 1'b0;
            r_data[k]  = 8'h00;
            r_last[k]  = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            rxq[i].delete();
            rdy_pat[i].delete();
            held[i]    = 1'b0;
            nerr[i]    = 0;
            exp_cnt[i] = 0;
            ptr[i]     = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_tb();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_tb();
        for (int k = 0; k < 4; k++) r_valid[k] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            o_ready[i]  = 1'b1;
            rdy_rand[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_flags%0d", i), {12'b0, o_valid[i], o_last[i], o_src[i], ferr[i]}, 16'h0);
            chk($sformatf("rst_data%0d", i), 16'(o_data[i]), 16'h0);
            chk($sformatf("rst_cnt%0d", i), 16'(fcnt[i]), 16'h0);
            chk($sformatf("rst_ready%0d", i), {14'b0, r_ready[2 * i], r_ready[2 * i + 1]}, 16'h0);
        end
        clear_tb();
        @(negedge clk);
        rst = 1'b0;

        // single zero byte
        add_frame(0, 1, 0);
        run_check(0, 64);
        chk("zero_b0", 16'(rxq[0][0]), 16'h000);
        chk("zero_b1", 16'(rxq[0][1]), 16'h0FD);
        chk("zero_b2", 16'(rxq[0][2]), 16'h102);
        chk("zero_cnt", 16'(fcnt[0]), 16'd1);

        // both requesters, two 2-byte frames each
        do_reset();
        add_frame(0, 2); add_frame(0, 2);
        add_frame(1, 2); add_frame(1, 2);
        run_check(0, 64);
        for (int f = 0; f < 4; f++)
            chk($sformatf("rr_src%0d", f), 16'(rxq[0][4 * f][9]), 16'(f % 2));

        // stalls during a 4-byte payload
        rdy_pat[0] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1};
        add_frame(0, 4);
        run_check(0, 64);

        // truncation at MAX_LEN=4
        add_frame(3, 6);
        run_check(1, 4);
        chk("trunc_err", 16'(nerr[1]), 16'd1);
        chk("trunc_cnt", 16'(fcnt[1]), 16'd2);
        chk("trunc_f2_len", 16'(rxq[1].size()), 16'd10);

        // asynchronous reset mid-frame
        do_reset();
        add_frame(0, 4);
        cyc = 0;
        while (txq[0].size() > 2 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("rst_mid_wait", 16'(cyc < 200), 16'd1);
        chk("rst_mid_pre_valid", 16'(o_valid[0]), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_flags", {12'b0, o_valid[0], o_last[0], o_src[0], ferr[0]}, 16'h0);
        chk("rst_mid_data", 16'(o_data[0]), 16'h0);
        chk("rst_mid_ready", 16'(r_ready[0]), 16'h0);
        chk("rst_mid_cnt", 16'(fcnt[0]), 16'h0);
        clear_tb();
        @(negedge clk);
        rst = 1'b0;
        add_frame(1, 1, 0);
        run_check(0, 64);
        chk("post_rst_hi", 16'(rxq[0][1]), 16'h2FD);
        chk("post_rst_lo", 16'(rxq[0][2]), 16'h302);

        // randomized frames with random backpressure
        rdy_rand[0] = 1'b1;
        rdy_rand[1] = 1'b1;
        for (int rnd = 0; rnd < 3; rnd++) begin
            if (rnd == 0) begin
                add_frame(0, 64);
                add_frame(1, 65);
            end
            for (int k = 0; k < 2; k++) begin
                int nf;
                nf = $urandom_range(0, 4);
                for (int f = 0; f < nf; f++) add_frame(k, $urandom_range(1, 70));
            end
            run_check(0, 64);
            for (int k = 2; k < 4; k++) begin
                int nf;
                nf = $urandom_range(1, 6);
                for (int f = 0; f < nf; f++) add_frame(k, $urandom_range(1, 6));
            end
            run_check(1, 4);
        end
        rdy_rand[0] = 1'b0;
        rdy_rand[1] = 1'b0;

        // frame counter wrap
        do_reset();
        for (int f = 0; f < 255; f++) add_frame(2 + (f % 2), 1);
        run_check(1, 4);
        chk("cnt_255", 16'(fcnt[1]), 16'd255);
        add_frame(2, 1);
        run_check(1, 4);
        chk("cnt_wrap", 16'(fcnt[1]), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
